digit_scan: RTL

DIGIT_SCAN -- requirements
Module: digit_scan

---
 rtl/digit_scan.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/digit_scan.sv
// digit_scan: time-multiplexed scanner for a four-digit hex display.
// A prescaler divides clk into digit slots; the slot index walks 0..3.
// Newly loaded values wait in a shadow register and are transferred to the
// display register only at the frame boundary (index 3 -> 0), so a frame never
// shows digits from two different values. All outputs are flops fed from
// next-state values, so a new slot appears the cycle after its tick and no
// input reaches an output without passing a register.
module digit_scan #(
   parameter int unsigned DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] value,
   input  logic        blank_lz,
   output logic [3:0]  nibble,
   output logic [3:0]  digit_en,
   output logic        blank,
   output logic        pending
);

   localparam logic [19:0] CNT_LAST = 20'(DIV - 1);

   logic [19:0] cnt_r, cnt_s;
   logic [1:0]  idx_r, idx_s;
   logic [15:0] disp_r, disp_s;
   logic [15:0] shadow_r, shadow_s;
   logic        pending_r, pending_s;
   logic [3:0]  nibble_r, nibble_s;
   logic [3:0]  digit_en_r, digit_en_s;
   logic        blank_r, blank_s;
   logic        tick_s;
   logic        frame_s;

   // Leading-zero test: slot i is blank when enabled and digits i..3 are all zero.
   // Slot 0 always shows its digit so a zero value still displays "0".
   function automatic logic lz_blank(input logic [15:0] d,
                                     input logic [1:0]  i,
                                     input logic        en);
      logic zero;
      case (i)
         2'd1:    zero = (d[15:4]  == 12'd0);
         2'd2:    zero = (d[15:8]  == 8'd0);
         2'd3:    zero = (d[15:12] == 4'd0);
         default: zero = 1'b0;
      endcase
      return en && zero;
   endfunction

   // Select the hex digit of a display word for a given slot.
   function automatic logic [3:0] digit_of(input logic [15:0] d,
                                           input logic [1:0]  i);
      logic [3:0] n;
      case (i)
         2'd0:    n = d[3:0];
         2'd1:    n = d[7:4];
         2'd2:    n = d[11:8];
         2'd3:    n = d[15:12];
         default: n = 4'd0;
      endcase
      return n;
   endfunction

   // Next-state for prescaler, slot index, shadow/display transfer and outputs.
   always_comb begin
      cnt_s      = cnt_r;
      idx_s      = idx_r;
      disp_s     = disp_r;
      shadow_s   = shadow_r;
      pending_s  = pending_r;
      nibble_s   = nibble_r;
      digit_en_s = digit_en_r;
      blank_s    = blank_r;

      tick_s  = (cnt_r == CNT_LAST);
      frame_s = tick_s && (idx_r == 2'd3);

      if (tick_s) begin
         cnt_s = 20'd0;
         idx_s = idx_r + 2'd1;
      end else begin
         cnt_s = cnt_r + 20'd1;
      end

      if (frame_s) begin
         if (load) begin
            // A load on the boundary goes straight to the display: newest wins.
            shadow_s  = value;
            disp_s    = value;
            pending_s = 1'b0;
         end else if (pending_r) begin
            disp_s    = shadow_r;
            pending_s = 1'b0;
         end else begin
            pending_s = pending_r;
         end
      end else if (load) begin
         shadow_s  = value;
         pending_s = 1'b1;
      end else begin
         pending_s = pending_r;
      end

      nibble_s = digit_of(disp_s, idx_s);
      case (idx_s)
         2'd0:    digit_en_s = 4'b0001;
         2'd1:    digit_en_s = 4'b0010;
         2'd2:    digit_en_s = 4'b0100;
         2'd3:    digit_en_s = 4'b1000;
         default: digit_en_s = 4'b0001;
      endcase
      blank_s = lz_blank(disp_s, idx_s, blank_lz);
   end

   // State and output registers with synchronous reset overriding any load.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r      <= 20'd0;
         idx_r      <= 2'd0;
         disp_r     <= 16'd0;
         shadow_r   <= 16'd0;
         pending_r  <= 1'b0;
         nibble_r   <= 4'd0;
         digit_en_r <= 4'b0001;
         blank_r    <= 1'b0;
      end else begin
         cnt_r      <= cnt_s;
         idx_r      <= idx_s;
         disp_r     <= disp_s;
         shadow_r   <= shadow_s;
         pending_r  <= pending_s;
         nibble_r   <= nibble_s;
         digit_en_r <= digit_en_s;
         blank_r    <= blank_s;
      end
   end

   assign nibble   = nibble_r;
   assign digit_en = digit_en_r;
   assign blank    = blank_r;
   assign pending  = pending_r;

endmodule
